// File: rtl/dice_result_producer.sv
// Turns per-frame die classifications from the camera pipeline into one stable,
// single-cycle dice_valid pulse per roll for game_logic, plus a frame-tick stall watchdog.
module dice_result_producer #(
  parameter int CLEAR_FRAMES  = 4,
  parameter int STABLE_FRAMES = 8,
  parameter int STALL_CYCLES  = 4_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll_en,
  input  logic       frame_tick,
  input  logic       det_valid,
  input  logic [1:0] det_value,
  output logic       dice_valid,
  output logic [1:0] dice_value,
  output logic [1:0] state_dbg,
  output logic       cam_stall
);

  localparam int CW = $clog2(CLEAR_FRAMES + 1);
  localparam int SW = $clog2(STABLE_FRAMES + 1);
  localparam int WW = $clog2(STALL_CYCLES + 1);

  localparam logic [CW-1:0] CLEAR_MAX  = CW'(CLEAR_FRAMES);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);
  localparam logic [WW-1:0] STALL_MAX  = WW'(STALL_CYCLES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CLEAR = 2'd1,
    TRACK      = 2'd2,
    EMIT       = 2'd3
  } state_t;

  // Handshake: dice_valid is a one-cycle pulse with no ready; game_logic must
  // accept it in that cycle. dice_value is stable with the pulse and held after.
  state_t        state_q, state_d;
  logic [CW-1:0] clear_cnt_q, clear_cnt_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic [1:0]    candidate_q, candidate_d;
  logic          dice_valid_q, dice_valid_d;
  logic [1:0]    dice_value_q, dice_value_d;
  logic [WW-1:0] stall_cnt_q, stall_cnt_d;
  logic          cam_stall_q, cam_stall_d;

  always_comb begin
    state_d      = state_q;
    clear_cnt_d  = clear_cnt_q;
    stable_cnt_d = stable_cnt_q;
    candidate_d  = candidate_q;
    dice_valid_d = 1'b0;
    dice_value_d = dice_value_q;

    case (state_q)
      IDLE: begin
        if (roll_en) begin
          state_d      = WAIT_CLEAR;
          clear_cnt_d  = '0;
          stable_cnt_d = '0;
        end
      end

      WAIT_CLEAR: begin
        // Abort wins over a tick that would otherwise finish the clear count.
        if (!roll_en) begin
          state_d      = IDLE;
          clear_cnt_d  = '0;
          stable_cnt_d = '0;
        end else if (frame_tick) begin
          if (det_valid) begin
            clear_cnt_d = '0;
          end else if (clear_cnt_q != CLEAR_MAX) begin
            clear_cnt_d = clear_cnt_q + CW'(1);
          end
          if (clear_cnt_d == CLEAR_MAX) begin
            state_d      = TRACK;
            stable_cnt_d = '0;
          end
        end
      end

      TRACK: begin
        if (!roll_en) begin
          state_d      = IDLE;
          clear_cnt_d  = '0;
          stable_cnt_d = '0;
        end else if (frame_tick) begin
          if (det_valid) begin
            if (stable_cnt_q != '0 && det_value == candidate_q) begin
              if (stable_cnt_q != STABLE_MAX) stable_cnt_d = stable_cnt_q + SW'(1);
            end else begin
              candidate_d  = det_value;
              stable_cnt_d = SW'(1);
            end
          end else begin
            stable_cnt_d = '0;
          end
          if (stable_cnt_d == STABLE_MAX) begin
            state_d      = EMIT;
            dice_valid_d = 1'b1;
            dice_value_d = candidate_d;
          end
        end
      end

      EMIT: begin
        // Re-arming goes through WAIT_CLEAR so the same die cannot count twice.
        state_d      = roll_en ? WAIT_CLEAR : IDLE;
        clear_cnt_d  = '0;
        stable_cnt_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (frame_tick) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + WW'(1);
    end
    cam_stall_d = (stall_cnt_d == STALL_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      clear_cnt_q  <= '0;
      stable_cnt_q <= '0;
      candidate_q  <= '0;
      dice_valid_q <= 1'b0;
      dice_value_q <= '0;
      stall_cnt_q  <= '0;
      cam_stall_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_cnt_q  <= clear_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      candidate_q  <= candidate_d;
      dice_valid_q <= dice_valid_d;
      dice_value_q <= dice_value_d;
      stall_cnt_q  <= stall_cnt_d;
      cam_stall_q  <= cam_stall_d;
    end
  end

  assign dice_valid = dice_valid_q;
  assign dice_value = dice_value_q;
  assign state_dbg  = state_q;
  assign cam_stall  = cam_stall_q;

endmodule

// File: tb/tb_dice_result_producer.sv
// Bench for dice_result_producer: directed roll scenarios plus random frame streams
// compared against a window-based model of the clear/stable rules.
module tb_dice_result_producer;

  localparam int CLR   = 2;
  localparam int STB   = 3;
  localparam int STALL = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       roll_en;
  logic       frame_tick;
  logic       det_valid;
  logic [1:0] det_value;
  logic       dice_valid;
  logic [1:0] dice_value;
  logic [1:0] state_dbg;
  logic       cam_stall;

  int n_run  = 0;
  int n_fail = 0;

  int         tick_idx;
  int         pulse_tick[$];
  logic [1:0] pulse_val[$];
  logic       prev_dv = 1'b0;
  int         dbl_cnt = 0;

  bit         fv_q[$];
  logic [1:0] fd_q[$];
  int         exp_idx_q[$];
  logic [1:0] exp_q[$];

  dice_result_producer #(
    .CLEAR_FRAMES (CLR),
    .STABLE_FRAMES(STB),
    .STALL_CYCLES (STALL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .roll_en   (roll_en),
    .frame_tick(frame_tick),
    .det_valid (det_valid),
    .det_value (det_value),
    .dice_valid(dice_valid),
    .dice_value(dice_value),
    .state_dbg (state_dbg),
    .cam_stall (cam_stall)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs, let the edge happen, sample 1 time unit later.
  // det_* are randomised on non-tick cycles since they must be ignored there.
  task automatic step(input bit tick, input bit v, input logic [1:0] val);
    int this_idx;
    this_idx   = tick_idx;
    frame_tick = tick;
    det_valid  = tick ? v : 1'($urandom);
    det_value  = tick ? val : 2'($urandom);
    @(posedge clk);
    #1;
    if (tick) tick_idx++;
    if (dice_valid === 1'b1) begin
      pulse_tick.push_back(tick ? this_idx : -1);
      pulse_val.push_back(dice_value);
      if (prev_dv === 1'b1) dbl_cnt++;
    end
    prev_dv = dice_valid;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0);
  endtask

  task automatic frame(input bit v, input logic [1:0] val);
    step(1'b1, v, val);
    idle($urandom_range(1, 3));
  endtask

  task automatic clear_frames(input int n);
    repeat (n) frame(1'b0, 2'd0);
  endtask

  task automatic clear_log();
    tick_idx = 0;
    pulse_tick.delete();
    pulse_val.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // A pulse lands on tick i when, after the previous pulse (or roll start),
  // some window of CLR no-die frames ends at c, and frames i-STB+1..i are all
  // valid and equal with i-STB+1 > c; the earliest such c and i win.
  function automatic void run_model();
    int  p, n, c, i;
    bit  ok;
    p = 0;
    n = fv_q.size();
    exp_idx_q.delete();
    exp_q.delete();
    while (1) begin
      c = -1;
      for (int k = p + CLR - 1; k < n && c < 0; k++) begin
        ok = 1'b1;
        for (int j = k - CLR + 1; j <= k; j++) if (fv_q[j]) ok = 1'b0;
        if (ok) c = k;
      end
      if (c < 0) break;
      i = -1;
      for (int k = c + STB; k < n && i < 0; k++) begin
        ok = 1'b1;
        for (int j = k - STB + 1; j <= k; j++)
          if (!fv_q[j] || fd_q[j] !== fd_q[k]) ok = 1'b0;
        if (ok) i = k;
      end
      if (i < 0) break;
      exp_idx_q.push_back(i);
      exp_q.push_back(fd_q[i]);
      p = i + 1;
    end
  endfunction

  task automatic test_reset();
    roll_en = 1'b0;
    do_reset();
    n_run++; if (dice_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dice_valid: got %0b expected 0", dice_valid); end
    n_run++; if (dice_value !== 2'd0) begin n_fail++; $display("FAIL reset_dice_value: got %0d expected 0", dice_value); end
    n_run++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    n_run++; if (cam_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cam_stall: got %0b expected 0", cam_stall); end
  endtask

  task automatic test_basic_roll();
    do_reset();
    clear_log();
    roll_en = 1'b1;
    idle(1);
    n_run++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL basic_wait_clear: got %0d expected 1", state_dbg); end
    step(1'b1, 1'b0, 2'd0); idle(1);
    step(1'b1, 1'b0, 2'd0);
    n_run++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL basic_track: got %0d expected 2", state_dbg); end
    idle(1);
    step(1'b1, 1'b1, 2'd2); idle(1);
    step(1'b1, 1'b1, 2'd2);
    n_run++; if (dice_valid !== 1'b0 || state_dbg !== 2'd2) begin n_fail++; $display("FAIL basic_early: got dv=%0b st=%0d expected dv=0 st=2", dice_valid, state_dbg); end
    idle(1);
    step(1'b1, 1'b1, 2'd2);
    n_run++; if (dice_valid !== 1'b1 || dice_value !== 2'd2 || state_dbg !== 2'd3) begin n_fail++; $display("FAIL basic_emit: got dv=%0b val=%0d st=%0d expected dv=1 val=2 st=3", dice_valid, dice_value, state_dbg); end
    idle(1);
    n_run++; if (dice_valid !== 1'b0 || state_dbg !== 2'd1 || dice_value !== 2'd2) begin n_fail++; $display("FAIL basic_after: got dv=%0b st=%0d val=%0d expected dv=0 st=1 val=2", dice_valid, state_dbg, dice_value); end
    idle(3);
    n_run++; if (pulse_tick.size() != 1 || pulse_tick[0] != 4) begin n_fail++; $display("FAIL basic_pulses: got %0d pulses expected 1 at tick 4", pulse_tick.size()); end
  endtask

  task automatic test_candidate_change();
    logic [1:0] seq [5] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
    do_reset();
    clear_log();
    roll_en = 1'b1;
    idle(1);
    clear_frames(2);
    foreach (seq[k]) frame(1'b1, seq[k]);
    n_run++; if (pulse_tick.size() != 1) begin n_fail++; $display("FAIL cand_count: got %0d expected 1", pulse_tick.size()); end
    else begin
      n_run++; if (pulse_tick[0] != 6 || pulse_val[0] !== 2'd3) begin n_fail++; $display("FAIL cand_pulse: got tick %0d val %0d expected tick 6 val 3", pulse_tick[0], pulse_val[0]); end
    end
  endtask

  task automatic test_occlusion();
    do_reset();
    clear_log();
    roll_en = 1'b1;
    idle(1);
    clear_frames(2);
    frame(1'b1, 2'd2); frame(1'b1, 2'd2); frame(1'b0, 2'd2);
    frame(1'b1, 2'd2); frame(1'b1, 2'd2);
    n_run++; if (pulse_tick.size() != 0 || state_dbg !== 2'd2) begin n_fail++; $display("FAIL occl_nopulse: got %0d pulses st=%0d expected 0 pulses st=2", pulse_tick.size(), state_dbg); end
    frame(1'b1, 2'd2);
    n_run++; if (pulse_tick.size() != 1 || pulse_tick[0] != 7 || pulse_val[0] !== 2'd2) begin n_fail++; $display("FAIL occl_pulse: got %0d pulses expected 1 at tick 7 val 2", pulse_tick.size()); end
    clear_frames(1);
    frame(1'b1, 2'd1);
    clear_frames(1);
    n_run++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL clear_restart: got st=%0d expected 1", state_dbg); end
    clear_frames(1);
    n_run++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL clear_done: got st=%0d expected 2", state_dbg); end
  endtask

  task automatic test_abort_rearm();
    do_reset();
    clear_log();
    roll_en = 1'b1;
    idle(1);
    clear_frames(2);
    frame(1'b1, 2'd3); frame(1'b1, 2'd3); frame(1'b1, 2'd3);
    clear_frames(2);
    frame(1'b1, 2'd1); frame(1'b1, 2'd1);
    roll_en = 1'b0;
    step(1'b1, 1'b1, 2'd1);
    n_run++; if (dice_valid !== 1'b0 || state_dbg !== 2'd0 || dice_value !== 2'd3) begin n_fail++; $display("FAIL abort: got dv=%0b st=%0d val=%0d expected dv=0 st=0 val=3", dice_valid, state_dbg, dice_value); end
    idle(2);
    n_run++; if (pulse_tick.size() != 1) begin n_fail++; $display("FAIL abort_count: got %0d expected 1", pulse_tick.size()); end
    roll_en = 1'b1;
    idle(1);
    clear_frames(2);
    frame(1'b1, 2'd2); frame(1'b1, 2'd2); frame(1'b1, 2'd2);
    repeat (10) frame(1'b1, 2'd2);
    n_run++; if (pulse_tick.size() != 2 || state_dbg !== 2'd1) begin n_fail++; $display("FAIL rearm_hold: got %0d pulses st=%0d expected 2 pulses st=1", pulse_tick.size(), state_dbg); end
    clear_frames(2);
    frame(1'b1, 2'd2); frame(1'b1, 2'd2); frame(1'b1, 2'd2);
    n_run++; if (pulse_tick.size() != 3 || pulse_tick[2] != 29 || pulse_val[2] !== 2'd2) begin n_fail++; $display("FAIL rearm_pulse: got %0d pulses expected 3 with last at tick 29 val 2", pulse_tick.size()); end
  endtask

  task automatic test_reset_mid_track();
    clear_log();
    roll_en = 1'b1;
    clear_frames(2);
    frame(1'b1, 2'd1); frame(1'b1, 2'd1);
    reset = 1'b1;
    idle(1);
    n_run++; if (dice_valid !== 1'b0 || dice_value !== 2'd0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL midreset: got dv=%0b val=%0d st=%0d expected 0 0 0", dice_valid, dice_value, state_dbg); end
    reset = 1'b0;
    idle(1);
    frame(1'b1, 2'd1); frame(1'b1, 2'd1); frame(1'b1, 2'd1);
    n_run++; if (pulse_tick.size() != 0) begin n_fail++; $display("FAIL midreset_noclear: got %0d pulses expected 0", pulse_tick.size()); end
    clear_frames(2);
    frame(1'b1, 2'd1); frame(1'b1, 2'd1); frame(1'b1, 2'd1);
    n_run++; if (pulse_tick.size() != 1 || pulse_tick[0] != 11 || pulse_val[0] !== 2'd1) begin n_fail++; $display("FAIL midreset_roll: got %0d pulses expected 1 at tick 11 val 1", pulse_tick.size()); end
  endtask

  task automatic test_stall();
    bit bad_state;
    bad_state = 1'b0;
    roll_en = 1'b1;
    do_reset();
    for (int i = 1; i <= 120; i++) begin
      idle(1);
      if (state_dbg !== 2'd1) bad_state = 1'b1;
      if (i == 99) begin
        n_run++; if (cam_stall !== 1'b0) begin n_fail++; $display("FAIL stall_early: got %0b expected 0 at cycle 99", cam_stall); end
      end
      if (i == 100 || i == 120) begin
        n_run++; if (cam_stall !== 1'b1) begin n_fail++; $display("FAIL stall_set: got %0b expected 1 at cycle %0d", cam_stall, i); end
      end
    end
    n_run++; if (bad_state) begin n_fail++; $display("FAIL stall_state: got state change expected state 1 throughout"); end
    step(1'b1, 1'b0, 2'd0);
    n_run++; if (cam_stall !== 1'b0 || state_dbg !== 2'd1) begin n_fail++; $display("FAIL stall_clear: got cs=%0b st=%0d expected cs=0 st=1", cam_stall, state_dbg); end
  endtask

  task automatic test_random_stream();
    bit         v;
    logic [1:0] val;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      clear_log();
      fv_q.delete();
      fd_q.delete();
      roll_en = 1'b1;
      idle(1);
      val = 2'($urandom);
      for (int f = 0; f < 80; f++) begin
        v = ($urandom_range(0, 99) < 65);
        if ($urandom_range(0, 99) >= 70) val = 2'($urandom);
        fv_q.push_back(v);
        fd_q.push_back(val);
        frame(v, val);
      end
      run_model();
      n_run++; if (pulse_tick.size() != exp_idx_q.size()) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", r, pulse_tick.size(), exp_idx_q.size()); end
      else begin
        foreach (exp_q[k]) begin
          n_run++; if (pulse_tick[k] != exp_idx_q[k] || pulse_val[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_pulse[%0d.%0d]: got tick %0d val %0d expected tick %0d val %0d", r, k, pulse_tick[k], pulse_val[k], exp_idx_q[k], exp_q[k]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    n_run++; if (dbl_cnt != 0) begin n_fail++; $display("FAIL back_to_back: got %0d consecutive-cycle pulses expected 0", dbl_cnt); end
  endtask

  initial begin
    reset      = 1'b1;
    roll_en    = 1'b0;
    frame_tick = 1'b0;
    det_valid  = 1'b0;
    det_value  = 2'd0;
    tick_idx   = 0;
    test_reset();
    test_basic_roll();
    test_candidate_change();
    test_occlusion();
    test_abort_rearm();
    test_reset_mid_track();
    test_stall();
    test_random_stream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
